// File: rtl/affine_seq.sv
// Sequencer for an external affine/add ALU: captures one request, drives the
// ALU operand bus through its load phases and registers the ALU result.
//
// state | meaning
// IDLE  | waiting for a request (in_ready = 1)
// LD_X  | x-row operands {b1, c12, y, c11, x} loaded into the ALU
// LD_Y  | y-row operands {b2, c22, y, c21, x} loaded; x-row result captured
// CAP_Y | final ALU result captured (add mode dwells two cycles here)
// DONE  | result held on xo/yo until out_ready
module affine_seq #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [BUS_WIDTH-1:0]   x,
  input  logic [BUS_WIDTH-1:0]   y,
  input  logic [BUS_WIDTH-1:0]   c11,
  input  logic [BUS_WIDTH-1:0]   c12,
  input  logic [BUS_WIDTH-1:0]   c21,
  input  logic [BUS_WIDTH-1:0]   c22,
  input  logic [BUS_WIDTH-1:0]   b1,
  input  logic [BUS_WIDTH-1:0]   b2,
  output logic [5*BUS_WIDTH-1:0] alu_ops,
  output logic [4:0]             alu_reg_en,
  output logic                   alu_f_add,
  input  logic [BUS_WIDTH-1:0]   alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BUS_WIDTH-1:0]   xo,
  output logic [BUS_WIDTH-1:0]   yo
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_X  = 3'd1,
    LD_Y  = 3'd2,
    CAP_Y = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                 mode_r;
  logic [BUS_WIDTH-1:0] x_r, y_r, c11_r, c12_r, c21_r, c22_r, b1_r, b2_r;
  logic                 accept;
  logic                 cap_cnt, cap_cnt_nxt;
  logic                 ld_xo, ld_yo;
  logic [BUS_WIDTH-1:0] yo_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cap_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      cap_cnt <= cap_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mode_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      c11_r  <= '0;
      c12_r  <= '0;
      c21_r  <= '0;
      c22_r  <= '0;
      b1_r   <= '0;
      b2_r   <= '0;
    end else if (accept) begin
      mode_r <= mode;
      x_r    <= x;
      y_r    <= y;
      c11_r  <= c11;
      c12_r  <= c12;
      c21_r  <= c21;
      c22_r  <= c22;
      b1_r   <= b1;
      b2_r   <= b2;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      xo <= '0;
      yo <= '0;
    end else begin
      if (ld_xo) xo <= alu_result;
      if (ld_yo) yo <= yo_d;
    end
  end

  // The ALU result lags its operand load by one edge, so each row's result
  // is captured in the state after that row was loaded.
  always_comb begin
    state_nxt   = state;
    cap_cnt_nxt = cap_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    alu_ops     = '0;
    alu_reg_en  = '0;
    alu_f_add   = 1'b0;
    ld_xo       = 1'b0;
    ld_yo       = 1'b0;
    yo_d        = alu_result;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = LD_X;
        end
      end
      LD_X: begin
        alu_ops    = {b1_r, c12_r, y_r, c11_r, x_r};
        alu_reg_en = 5'b11111;
        alu_f_add  = mode_r;
        state_nxt  = mode_r ? CAP_Y : LD_Y;
        // add mode skips LD_Y, so it dwells an extra cycle in CAP_Y
        cap_cnt_nxt = mode_r;
      end
      LD_Y: begin
        alu_ops     = {b2_r, c22_r, y_r, c21_r, x_r};
        alu_reg_en  = 5'b11111;
        ld_xo       = 1'b1;
        state_nxt   = CAP_Y;
        cap_cnt_nxt = 1'b0;
      end
      CAP_Y: begin
        alu_f_add = mode_r;
        if (cap_cnt == 1'b0) begin
          state_nxt = DONE;
          ld_yo     = 1'b1;
          if (mode_r) begin
            ld_xo = 1'b1;
            yo_d  = '0;
          end
        end else begin
          cap_cnt_nxt = cap_cnt - 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
